// File: rtl/i2s_pkg.sv
// Shared types and constants for the WM8731 I2S playback path.
//   state_e      : transmitter FSM state (idle / streaming / finishing last frame)
//   B_DEFAULT    : default FIFO word width ({left, right} halves)
//   slot_width() : counter width needed to count 2*slot bit slots per frame
package i2s_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned B_DEFAULT = 32;

    function automatic int unsigned slot_width(input int unsigned slot);
        return (slot > 1) ? $clog2(2 * slot) : 1;
    endfunction

endpackage

// File: rtl/wm8731_bclk_gen.sv
// Bit-clock generator for the WM8731 in I2S master mode.
// Divides clk by 2*CLK_DIV while run is high; holds bclk low and the divider
// at zero otherwise, so a new run always starts from a clean phase.
//   clk, reset : system clock, synchronous active-high reset
//   run        : divider enable
//   bclk       : registered bit clock
//   rise_evt   : 1-cycle pulse in the cycle right after bclk rose
//   fall_evt   : 1-cycle pulse in the cycle right after bclk fell
//   pre_fall   : high in the clk cycle whose closing edge makes bclk fall
module wm8731_bclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic rise_evt,
    output logic fall_evt,
    output logic pre_fall
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TermCnt = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          toggle;

    always_comb begin
        toggle = run && (div_q == TermCnt);
        div_d  = '0;
        bclk_d = 1'b0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (run) begin
            div_d  = toggle ? '0 : div_q + CW'(1);
            bclk_d = bclk_q ^ toggle;
            rise_d = toggle && !bclk_q;
            fall_d = toggle && bclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bclk_q <= bclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bclk     = bclk_q;
    assign rise_evt = rise_q;
    assign fall_evt = fall_q;
    assign pre_fall = toggle && bclk_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter feeding the WM8731 DAC from a first-word-fall-through
// FIFO. Each FIFO word {left, right} is played MSB first, one frame per word,
// with the standard I2S one-bit delay after each daclrc transition.
//   clk, reset  : system clock, synchronous active-high reset
//   enable      : level run request; dropping it finishes the current frame
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO head word (valid while not empty)
//   fifo_rd     : pop strobe, high in the cycle before a frame starts
//   bclk        : bit clock (registered)
//   daclrc      : channel select, 0 = left, 1 = right (registered)
//   dacdat      : serial data, changes on bclk falling edges (registered)
//   underrun    : 1-cycle pulse when a frame starts with the FIFO empty
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int unsigned B       = B_DEFAULT,  // must be even
    parameter int unsigned CLK_DIV = 4           // must be >= 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_data,
    output logic         fifo_rd,
    output logic         bclk,
    output logic         daclrc,
    output logic         dacdat,
    output logic         underrun
);

    localparam int unsigned SLOT = B / 2;
    localparam int unsigned SW   = slot_width(SLOT);
    localparam logic [SW-1:0] LastSlot   = SW'(2 * SLOT - 1);
    localparam logic [SW-1:0] FirstRight = SW'(SLOT);

    state_e        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d, slot_next;
    logic [B-1:0]  shift_q, shift_d;
    logic          daclrc_q, daclrc_d;
    logic          dacdat_q, dacdat_d;
    logic          first_q, first_d;  // next fall starts the first frame of a run
    logic          last_q, last_d;    // draining: the slot-0 tail bit is on the wire
    logic          run;
    logic          pre_fall;
    logic          rise_evt;
    logic          fall_evt;
    logic          boundary;
    logic          fetch;

    assign run = (state_q != StIdle);

    wm8731_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .bclk     (bclk),
        .rise_evt (rise_evt),
        .fall_evt (fall_evt),
        .pre_fall (pre_fall)
    );

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        shift_d   = shift_q;
        daclrc_d  = daclrc_q;
        dacdat_d  = dacdat_q;
        first_d   = first_q;
        last_d    = last_q;
        slot_next = slot_q + SW'(1);

        boundary = pre_fall && (first_q || (slot_q == LastSlot));
        fetch    = (state_q == StRun) && boundary;
        // Gated by reset so a reset landing on the fetch cycle never pops.
        fifo_rd  = fetch && !fifo_empty && !reset;
        underrun = fetch && fifo_empty && !reset;

        unique case (state_q)
            StIdle: begin
                slot_d   = '0;
                shift_d  = '0;
                daclrc_d = 1'b1;
                dacdat_d = 1'b0;
                first_d  = 1'b1;
                last_d   = 1'b0;
                if (enable) begin
                    state_d = StRun;
                end
            end
            StRun, StDrain: begin
                if ((state_q == StRun) && !enable) begin
                    state_d = StDrain;
                end
                if (pre_fall) begin
                    if (last_q) begin
                        state_d  = StIdle;
                        slot_d   = '0;
                        shift_d  = '0;
                        daclrc_d = 1'b1;
                        dacdat_d = 1'b0;
                        last_d   = 1'b0;
                    end else if (boundary) begin
                        // After 2*SLOT-1 shifts the MSB holds the previous right LSB,
                        // which is exactly the one-bit-delayed slot 0 value.
                        slot_d   = '0;
                        daclrc_d = 1'b0;
                        dacdat_d = shift_q[B-1];
                        first_d  = 1'b0;
                        if (state_q == StRun) begin
                            shift_d = fifo_empty ? '0 : fifo_data;
                        end else begin
                            shift_d = '0;
                            last_d  = 1'b1;
                        end
                    end else begin
                        slot_d   = slot_next;
                        daclrc_d = (slot_next >= FirstRight);
                        dacdat_d = shift_q[B-1];
                        shift_d  = shift_q << 1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            shift_q  <= '0;
            daclrc_q <= 1'b1;
            dacdat_q <= 1'b0;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shift_q  <= shift_d;
            daclrc_q <= daclrc_d;
            dacdat_q <= dacdat_d;
            first_q  <= first_d;
            last_q   <= last_d;
        end
    end

    assign daclrc = daclrc_q;
    assign dacdat = dacdat_q;

    // Edge pulses must agree with the bclk level they report.
    a_rise_level : assert property (@(posedge clk) disable iff (reset) rise_evt |-> bclk);
    a_fall_level : assert property (@(posedge clk) disable iff (reset) fall_evt |-> !bclk);

endmodule

// File: tb/tb_i2s_dac_tx.sv
module tb_i2s_dac_tx;

    localparam int unsigned B       = 32;
    localparam int unsigned CLK_DIV = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         fifo_empty;
    logic [B-1:0] fifo_data;
    logic         fifo_rd;
    logic         bclk;
    logic         daclrc;
    logic         dacdat;
    logic         underrun;

    logic [B-1:0] mem [16];
    int           rd_ptr  = 0;
    int           wr_ptr  = 0;
    int           cyc     = 0;
    int           pop_cnt = 0;
    int           ur_cnt  = 0;
    int           pop_cyc [8];
    int           n_cmp   = 0;
    int           n_err   = 0;

    always #5 clk = ~clk;

    i2s_dac_tx #(
        .B       (B),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .bclk       (bclk),
        .daclrc     (daclrc),
        .dacdat     (dacdat),
        .underrun   (underrun)
    );

    // First-word-fall-through FIFO model.
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr % 16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            rd_ptr <= rd_ptr + 1;
            if (pop_cnt < 8) pop_cyc[pop_cnt] <= cyc;
            pop_cnt <= pop_cnt + 1;
        end
        if (underrun) ur_cnt <= ur_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [B-1:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    // Waits for the next bclk rising edge (sampled on negedges) and returns
    // the data and channel the codec latches there.
    task automatic next_rise(input string tag, output logic d, output logic lr);
        int guard = 0;
        while (bclk === 1'b1 && guard < 64) begin @(negedge clk); guard++; end
        while (bclk !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
        if (guard >= 64) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed no bclk rise in 64 cycles, expected a rise", tag);
        end
        d  = dacdat;
        lr = daclrc;
    endtask

    // Shifts n sampled slots in, oldest slot ending up most significant.
    task automatic capture(input string tag, input int n,
                           inout logic [31:0] bits, inout logic [31:0] lrs);
        logic d, lr;
        for (int i = 0; i < n; i++) begin
            next_rise(tag, d, lr);
            bits = {bits[30:0], d};
            lrs  = {lrs[30:0], lr};
        end
    endtask

    initial begin
        logic [31:0] bits, lrs;
        logic        d, lr;
        logic        bclk_seen, lr_low_seen, dat_seen;
        int          c0, guard;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_bclk",   32'(bclk),     32'd0);
        check("rst_daclrc", 32'(daclrc),   32'd1);
        check("rst_dacdat", 32'(dacdat),   32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        push(32'hA5A5_0F0F);
        push(32'h8001_0001);
        push(32'h1234_5678);
        push(32'hFFFF_0001);
        enable = 1'b1;

        // Start latency: cycle k is the interval after the k-th edge with enable high.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("start_bclk_c%0d", k),    32'(bclk),    32'(k >= 4 && k < 8));
            check($sformatf("start_rd_c%0d", k),      32'(fifo_rd), 32'(k == 7));
            check($sformatf("start_daclrc_c%0d", k),  32'(daclrc),  32'(k < 8));
        end

        bits = '0; lrs = '0;
        capture("frame1", 32, bits, lrs);
        check("frame1_bits", bits, 32'h52D2_8787);
        check("frame1_lr",   lrs,  32'h0000_FFFF);
        check("frame1_pops", 32'(pop_cnt), 32'd1);

        bits = '0; lrs = '0;
        capture("frame2", 32, bits, lrs);
        check("frame2_bits", bits, 32'hC000_8000);
        check("frame2_lr",   lrs,  32'h0000_FFFF);

        bits = '0; lrs = '0;
        capture("frame3", 32, bits, lrs);
        check("frame3_bits", bits, 32'h891A_2B3C);

        bits = '0; lrs = '0;
        capture("frame4", 32, bits, lrs);
        check("frame4_bits", bits, 32'h7FFF_8000);
        check("b2b_pops",    32'(pop_cnt), 32'd4);
        check("b2b_gap0",    32'(pop_cyc[1] - pop_cyc[0]), 32'd256);
        check("b2b_gap1",    32'(pop_cyc[2] - pop_cyc[1]), 32'd256);
        check("b2b_gap2",    32'(pop_cyc[3] - pop_cyc[2]), 32'd256);
        check("b2b_no_underrun", 32'(ur_cnt), 32'd0);

        // FIFO now empty: frame 5 underruns and plays silence after the tail bit.
        bits = '0; lrs = '0;
        capture("frame5", 32, bits, lrs);
        check("underrun_bits",  bits, 32'h8000_0000);
        check("underrun_lr",    lrs,  32'h0000_FFFF);
        check("underrun_pulse", 32'(ur_cnt),  32'd1);
        check("underrun_nopop", 32'(pop_cnt), 32'd4);

        push(32'h0001_0003);
        push(32'h5555_AAAA);

        // Drop enable during slot 5 of frame 6.
        bits = '0; lrs = '0;
        capture("frame6a", 6, bits, lrs);
        enable = 1'b0;
        capture("frame6b", 26, bits, lrs);
        check("drain_frame_bits", bits, 32'h0000_8001);
        check("drain_frame_lr",   lrs,  32'h0000_FFFF);

        next_rise("drain_tail", d, lr);
        check("drain_tail_dat", 32'(d),  32'd1);
        check("drain_tail_lr",  32'(lr), 32'd0);

        repeat (4) @(negedge clk);
        bclk_seen = 1'b0; lr_low_seen = 1'b0; dat_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bclk_seen   = bclk_seen | bclk;
            lr_low_seen = lr_low_seen | !daclrc;
            dat_seen    = dat_seen | dacdat;
        end
        check("idle_bclk_low",  32'(bclk_seen),   32'd0);
        check("idle_daclrc_hi", 32'(lr_low_seen), 32'd0);
        check("idle_dacdat_lo", 32'(dat_seen),    32'd0);
        check("drain_pops",     32'(pop_cnt),     32'd5);
        check("drain_fifo_cnt", 32'(wr_ptr - rd_ptr), 32'd1);
        check("drain_underruns", 32'(ur_cnt),     32'd1);

        // Restart, then reset across the next frame's fetch cycle.
        enable = 1'b1;
        guard = 0;
        while (pop_cnt < 6 && guard < 32) begin @(negedge clk); guard++; end
        check("restart_pop", 32'(pop_cnt), 32'd6);
        push(32'h0F0F_F0F0);
        push(32'h3333_CCCC);
        c0 = pop_cyc[5] + 256;
        guard = 0;
        while (cyc != c0 && guard < 400) begin @(negedge clk); guard++; end
        check("rst_reach_fetch", 32'(cyc), 32'(c0));
        check("rst_fetch_rd",    32'(fifo_rd), 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("rst_gates_rd", 32'(fifo_rd), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_mid_bclk",   32'(bclk),     32'd0);
        check("rst_mid_daclrc", 32'(daclrc),   32'd1);
        check("rst_mid_dacdat", 32'(dacdat),   32'd0);
        check("rst_mid_rd",     32'(fifo_rd),  32'd0);
        check("rst_mid_ur",     32'(underrun), 32'd0);
        check("rst_fifo_cnt",   32'(wr_ptr - rd_ptr), 32'd2);
        check("rst_pops",       32'(pop_cnt),  32'd6);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
